// File: rtl/systolic_feeder_if.sv
// Slice-input handshake and array-edge operand bundles for systolic_feeder.
// The feeder is the slave of the slice bundle and the master of the edge bundle.
interface feed_slice_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [N*8-1:0] a_in;
  logic [N*8-1:0] b_in;

  modport master (output in_valid, in_last, a_in, b_in, input in_ready);
  modport slave  (input in_valid, in_last, a_in, b_in, output in_ready);
endinterface

interface array_edge_if #(parameter int N = 4);
  logic [N*8-1:0] a_out;
  logic [N*8-1:0] b_out;
  logic           start;
  logic           enable;
  logic           push;

  modport master (output a_out, b_out, start, enable, push);
  modport slave  (input a_out, b_out, start, enable, push);
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN int8 systolic array: accepts k-slices, skews them
// onto the left/top edges, and sequences start/enable/done for one tile.
module systolic_feeder #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          reset,
  feed_slice_if.slave   slice,
  array_edge_if.master  arr,
  output logic          busy,
  output logic          done
);

  localparam int CW         = (N > 1) ? $clog2(2*N - 1) : 1;
  localparam int DRAIN_LAST = (N > 1) ? 2*N - 3 : 0;

  typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          ready_q;
  logic          start_q;
  logic          enable_q;

  logic accept;
  logic drain;
  logic advance;
  logic clear_stages;

  assign accept       = slice.in_valid & ready_q;
  assign drain        = (state == DRAIN);
  assign advance      = accept | drain;
  assign clear_stages = (state == START);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; outputs are registered alongside the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      enable_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      done     <= 1'b0;
      enable_q <= advance;
      case (state)
        IDLE: begin
          if (slice.in_valid) begin
            state   <= START;
            start_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        START: begin
          state   <= FEED;
          ready_q <= 1'b1;
        end
        FEED: begin
          if (accept && slice.in_last) begin
            ready_q   <= 1'b0;
            drain_cnt <= '0;
            state     <= (N == 1) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + CW'(1);
          if (drain_cnt == CW'(DRAIN_LAST)) state <= DONE;
        end
        DONE: begin
          // DONE spans the array's final enabled cycle; done fires after it.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i of A and lane i of B share the same i-stage skew depth.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [7:0] a_inj;
    logic [7:0] b_inj;
    logic [7:0] a_q;
    logic [7:0] b_q;

    assign a_inj = drain ? 8'd0 : slice.a_in[i*8 +: 8];
    assign b_inj = drain ? 8'd0 : slice.b_in[i*8 +: 8];

    if (i == 0) begin : g_direct
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_inj;
          b_q <= b_inj;
        end
      end
    end else begin : g_delay
      logic [7:0] a_stg [i];
      logic [7:0] b_stg [i];

      // NOTE: the delay-line storage is reset explicitly; a mid-tile reset
      // must leave no stale operands to leak into the next tile.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < i; k++) begin
            a_stg[k] <= '0;
            b_stg[k] <= '0;
          end
          a_q <= '0;
          b_q <= '0;
        end else if (clear_stages) begin
          for (int k = 0; k < i; k++) begin
            a_stg[k] <= '0;
            b_stg[k] <= '0;
          end
        end else if (advance) begin
          a_stg[0] <= a_inj;
          b_stg[0] <= b_inj;
          for (int k = 1; k < i; k++) begin
            a_stg[k] <= a_stg[k-1];
            b_stg[k] <= b_stg[k-1];
          end
          a_q <= a_stg[i-1];
          b_q <= b_stg[i-1];
        end
      end
    end

    assign arr.a_out[i*8 +: 8] = a_q;
    assign arr.b_out[i*8 +: 8] = b_q;
  end

  assign slice.in_ready = ready_q;
  assign arr.start      = start_q;
  assign arr.enable     = enable_q;
  assign arr.push       = 1'b0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-advance edge operands and the
// resulting array products are predicted from whole-tile arithmetic.
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = N * 8;

  logic clk = 1'b0;
  logic reset;
  logic busy, done, busy1, done1;

  always #5 clk = ~clk;

  feed_slice_if #(.N(N)) s_if ();
  array_edge_if #(.N(N)) e_if ();
  feed_slice_if #(.N(1)) s1_if ();
  array_edge_if #(.N(1)) e1_if ();

  systolic_feeder #(.N(N)) u_dut (
    .clk(clk), .reset(reset), .slice(s_if), .arr(e_if), .busy(busy), .done(done)
  );
  systolic_feeder #(.N(1)) u_dut1 (
    .clk(clk), .reset(reset), .slice(s1_if), .arr(e1_if), .busy(busy1), .done(done1)
  );

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  logic [2*W-1:0] exp_q[$];
  int             adv_q[$];
  int             c_q[$];
  logic [W-1:0]   cur_a[$];
  logic [W-1:0]   cur_b[$];

  int pe_a[N][N];
  int pe_b[N][N];
  int pe_c[N][N];
  int adv_cnt = 0;
  int since_en = 0;

  int rec_start[32];
  int rec_ready[32];
  int rec_en[32];
  int rec_done[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [W-1:0] v, input int i);
    logic signed [7:0] x;
    x = v[i*8 +: 8];
    return int'(x);
  endfunction

  // Reference: on advance t, edge lane i carries slice t-i (zero outside the tile);
  // the finished array holds C = sum_k A[:,k] * B[k,:].
  task automatic push_tile();
    int K;
    logic [W-1:0] a, b;
    K = cur_a.size();
    for (int t = 0; t < K + 2*N - 2; t++) begin
      a = '0;
      b = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < K) begin
          a[i*8 +: 8] = cur_a[t-i][i*8 +: 8];
          b[i*8 +: 8] = cur_b[t-i][i*8 +: 8];
        end
      end
      exp_q.push_back({a, b});
    end
    adv_q.push_back(K + 2*N - 2);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int sum;
        sum = 0;
        for (int k = 0; k < K; k++) sum += lane(cur_a[k], i) * lane(cur_b[k], j);
        c_q.push_back(sum);
      end
  endtask

  // Monitor: array model fed from the DUT's edge, compared against the queues.
  initial begin
    logic [2*W-1:0] e;
    int in_a, in_b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) pe_c[i][j] = 0;
        adv_cnt = 0;
      end else if (mon_en) begin
        since_en++;
        if (e_if.start) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) pe_c[i][j] = 0;
          adv_cnt = 0;
        end
        if (e_if.enable) begin
          adv_cnt++;
          since_en = 0;
          if (exp_q.size() == 0) check("unexpected_advance", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("a_out", e_if.a_out, e[2*W-1:W]);
            check("b_out", e_if.b_out, e[W-1:0]);
          end
          for (int i = N - 1; i >= 0; i--)
            for (int j = N - 1; j >= 0; j--) begin
              in_a = (j == 0) ? lane(e_if.a_out, i) : pe_a[i][j-1];
              in_b = (i == 0) ? lane(e_if.b_out, j) : pe_b[i-1][j];
              pe_c[i][j] += in_a * in_b;
              pe_a[i][j] = in_a;
              pe_b[i][j] = in_b;
            end
        end
        if (done) begin
          if (adv_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            check("advances_per_tile", adv_cnt, adv_q.pop_front());
            check("done_after_last_enable", since_en, 1);
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++) begin
                if (c_q.size() == 0) check("c_queue_empty", 1, 0);
                else check($sformatf("out_c_%0d_%0d", i, j), pe_c[i][j], c_q.pop_front());
              end
          end
        end
      end
    end
  end

  task automatic drive_tile(input int stall_pct, input int stall_before, input bit hold_after);
    int k, budget, stall_left;
    bit acc, stalled, seen;
    k = 0; budget = 0; stall_left = 0; stalled = 1'b0;
    push_tile();
    while (k < cur_a.size()) begin
      if (k == stall_before && k > 0 && !stalled) begin
        stall_left = 2;
        stalled = 1'b1;
      end
      if (stall_left > 0) begin
        stall_left--;
        s_if.in_valid = 1'b0;
      end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
        s_if.in_valid = 1'b0;
      end else begin
        s_if.in_valid = 1'b1;
        s_if.a_in     = cur_a[k];
        s_if.b_in     = cur_b[k];
        s_if.in_last  = (k == cur_a.size() - 1);
      end
      @(negedge clk);
      acc = s_if.in_valid && s_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      budget++;
      if (budget > 300) begin
        check("drive_timeout", 0, 1);
        break;
      end
    end
    if (hold_after) begin
      s_if.in_valid = 1'b1;
      for (int n = 0; n < 4*N + 8; n++) begin
        s_if.a_in    = W'($urandom());
        s_if.b_in    = W'($urandom());
        s_if.in_last = 1'($urandom());
        @(negedge clk);
        check("late_in_ready", s_if.in_ready, 0);
        seen = done;
        @(posedge clk);
        #1;
        if (seen) break;
        if (n == 4*N + 7) check("late_done_timeout", 0, 1);
      end
    end else begin
      s_if.in_valid = 1'b0;
      s_if.in_last  = 1'b0;
    end
  endtask

  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rec_start[c] = e_if.start;
      rec_ready[c] = s_if.in_ready;
      rec_en[c]    = e_if.enable;
      rec_done[c]  = done;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic make_identity_tile(input int diag);
    cur_a.delete();
    cur_b.delete();
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] a, b;
      a = '0;
      for (int j = 0; j < N; j++) b[j*8 +: 8] = 8'(4*k + j + 1);
      a[k*8 +: 8] = 8'(diag);
      cur_a.push_back(a);
      cur_b.push_back(b);
    end
  endtask

  task automatic make_random_tile(input int K);
    cur_a.delete();
    cur_b.delete();
    for (int k = 0; k < K; k++) begin
      cur_a.push_back(W'($urandom()));
      cur_b.push_back(W'($urandom()));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int accepts, budget;
    reset = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_last = 1'b0; s_if.a_in = '0; s_if.b_in = '0;
    s1_if.in_valid = 1'b0; s1_if.in_last = 1'b0; s1_if.a_in = '0; s1_if.b_in = '0;
    #1;
    check("rst_in_ready", s_if.in_ready, 0);
    check("rst_start", e_if.start, 0);
    check("rst_enable", e_if.enable, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_push", e_if.push, 0);
    check("rst_a_out", e_if.a_out, 0);
    check("rst_b_out", e_if.b_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Continuous identity tile with exact cycle timeline.
    make_identity_tile(1);
    fork
      drive_tile(0, -1, 1'b0);
      record(16);
    join
    for (int c = 0; c < 16; c++) begin
      check($sformatf("t1_start_c%0d", c), rec_start[c], (c == 1));
      check($sformatf("t1_ready_c%0d", c), rec_ready[c], (c >= 2 && c <= 5));
      check($sformatf("t1_enable_c%0d", c), rec_en[c], (c >= 3 && c <= 12));
      check($sformatf("t1_done_c%0d", c), rec_done[c], (c == 13));
    end
    wait_idle();

    // Same tile with two stall cycles after the second slice.
    make_identity_tile(1);
    fork
      drive_tile(0, 2, 1'b0);
      record(18);
    join
    check("t2_enable_c4", rec_en[4], 1);
    check("t2_enable_c5", rec_en[5], 0);
    check("t2_enable_c6", rec_en[6], 0);
    check("t2_enable_c7", rec_en[7], 1);
    for (int c = 0; c < 18; c++) check($sformatf("t2_done_c%0d", c), rec_done[c], (c == 15));
    wait_idle();

    // Skew: one slice of all 7s.
    cur_a.delete(); cur_b.delete();
    cur_a.push_back({N{8'd7}});
    cur_b.push_back({N{8'd7}});
    drive_tile(0, -1, 1'b0);
    wait_idle();

    // N = 1, K = 1: DRAIN skipped.
    s1_if.in_valid = 1'b1; s1_if.a_in = 8'h80; s1_if.b_in = 8'h80; s1_if.in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("n1_start_c%0d", c), e1_if.start, (c == 1));
      check($sformatf("n1_ready_c%0d", c), s1_if.in_ready, (c == 2));
      check($sformatf("n1_enable_c%0d", c), e1_if.enable, (c == 3));
      check($sformatf("n1_done_c%0d", c), done1, (c == 4));
      if (c == 3)
        check("n1_product", lane({{(W-8){1'b0}}, e1_if.a_out}, 0) * lane({{(W-8){1'b0}}, e1_if.b_out}, 0), 16384);
      acc = s1_if.in_valid && s1_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) s1_if.in_valid = 1'b0;
    end
    wait_idle();

    // Reset after two accepts of a partial tile.
    mon_en = 1'b0;
    accepts = 0; budget = 0;
    s_if.in_valid = 1'b1; s_if.in_last = 1'b0;
    while (accepts < 2 && budget < 50) begin
      s_if.a_in = W'($urandom()) | {N{8'h01}};
      s_if.b_in = W'($urandom()) | {N{8'h01}};
      @(negedge clk);
      acc = s_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) accepts++;
      budget++;
    end
    check("mid_reset_accepts", accepts, 2);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", s_if.in_ready, 0);
    check("mid_rst_start", e_if.start, 0);
    check("mid_rst_enable", e_if.enable, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_push", e_if.push, 0);
    check("mid_rst_a_out", e_if.a_out, 0);
    check("mid_rst_b_out", e_if.b_out, 0);
    s_if.in_valid = 1'b0;
    exp_q.delete(); adv_q.delete(); c_q.delete();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    make_identity_tile(-1);
    drive_tile(0, -1, 1'b0);
    wait_idle();

    // Valid held through DRAIN/DONE, then the next tile begins from START.
    make_random_tile(3);
    drive_tile(0, -1, 1'b1);
    make_random_tile(5);
    drive_tile(0, -1, 1'b0);

    // Randomized tiles with random stalls, back to back.
    for (int t = 0; t < 8; t++) begin
      make_random_tile(int'($urandom_range(1, 7)));
      drive_tile(25, -1, 1'b0);
    end

    for (int n = 0; n < 500 && (adv_q.size() != 0 || exp_q.size() != 0); n++) @(posedge clk);
    check("pending_tiles", adv_q.size(), 0);
    check("pending_advances", exp_q.size(), 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
